// File: rtl/deadlock_stall_detector.sv
// rtl/deadlock_stall_detector.sv - deadlock decision stage for the kernel deadlock monitor
//
// Declares a deadlock once every dataflow instance has been idle or blocked
// for STALL_CYCLES consecutive edges while no AXI-Stream port is waiting on
// the testbench. After the declaration the stage latches a diagnostic
// snapshot and stays there until reset.
//
// Ports:
//   clock            sole clock, rising edge
//   reset            synchronous, active-low
//   axis_block_sigs  [N_AXIS] 1 = port waiting on an external stream
//   inst_idle_sigs   [N_IDLE] idle flags; [N_INST-1:0] pair with inst_block_sigs
//   inst_block_sigs  [N_INST] 1 = instance blocked on FIFO / ap_continue
//   block            sticky deadlock flag
//   block_pulse      one-cycle strobe on deadlock declaration
//   blocked_mask     [N_INST] inst_block_sigs captured at declaration
//   first_blk_idx    [IDX_W] lowest set index of blocked_mask
//   abort_count      [16] saturating count of suspect windows that cleared
//   state            [2] RUN=0, SUSPECT=1, BLOCKED=2
module deadlock_stall_detector #(
  parameter int N_AXIS       = 2,
  parameter int N_INST       = 6,
  parameter int N_IDLE       = 9,
  parameter int STALL_CYCLES = 1024,
  parameter int CNT_W        = $clog2(STALL_CYCLES) + 1,
  parameter int IDX_W        = $clog2(N_INST)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_IDLE-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  output logic              block,
  output logic              block_pulse,
  output logic [N_INST-1:0] blocked_mask,
  output logic [IDX_W-1:0]  first_blk_idx,
  output logic [15:0]       abort_count,
  output logic [1:0]        state
);

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] SUSPECT = 2'd1;
  localparam logic [1:0] BLOCKED = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STALL_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             stuck;
  logic [IDX_W-1:0] low_idx;

  // Stuck: nothing waits on the testbench, every instance is idle or blocked,
  // at least one is genuinely blocked, and the kernel is not simply finished.
  always_comb begin
    stuck = (~|axis_block_sigs)
          & (&(inst_idle_sigs[N_INST-1:0] | inst_block_sigs))
          & (|inst_block_sigs)
          & (~&inst_idle_sigs);
  end

  // Lowest-index priority encoder; scanning downward lets the lowest set bit
  // overwrite any higher one.
  always_comb begin
    low_idx = '0;
    for (int i = N_INST - 1; i >= 0; i--) begin
      if (inst_block_sigs[i]) low_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= RUN;
      cnt           <= '0;
      block         <= 1'b0;
      block_pulse   <= 1'b0;
      blocked_mask  <= '0;
      first_blk_idx <= '0;
      abort_count   <= '0;
    end else begin
      block_pulse <= 1'b0;
      case (state)
        RUN: begin
          if (stuck) begin
            state <= SUSPECT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end
        SUSPECT: begin
          if (!stuck) begin
            state <= RUN;
            cnt   <= '0;
            if (abort_count != 16'hFFFF) abort_count <= abort_count + 16'd1;
          end else if (cnt == CNT_LAST) begin
            state         <= BLOCKED;
            block         <= 1'b1;
            block_pulse   <= 1'b1;
            blocked_mask  <= inst_block_sigs;
            first_blk_idx <= low_idx;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          // BLOCKED is terminal: everything holds until reset.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deadlock_stall_detector.sv
// tb/tb_deadlock_stall_detector.sv - directed self-checking bench for deadlock_stall_detector
module tb_deadlock_stall_detector;

  logic       clock;
  logic       reset;
  logic [1:0] axis_block_sigs;
  logic [8:0] inst_idle_sigs;
  logic [5:0] inst_block_sigs;
  logic       block;
  logic       block_pulse;
  logic [5:0] blocked_mask;
  logic [2:0] first_blk_idx;
  logic [15:0] abort_count;
  logic [1:0] state;

  int passed = 0;
  int total  = 0;

  deadlock_stall_detector #(
    .N_AXIS(2), .N_INST(6), .N_IDLE(9), .STALL_CYCLES(8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .block           (block),
    .block_pulse     (block_pulse),
    .blocked_mask    (blocked_mask),
    .first_blk_idx   (first_blk_idx),
    .abort_count     (abort_count),
    .state           (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_stuck();
    axis_block_sigs = 2'b00;
    inst_idle_sigs  = 9'h03E;
    inst_block_sigs = 6'h01;
  endtask

  task automatic drive_free();
    axis_block_sigs = 2'b00;
    inst_idle_sigs  = 9'h03E;
    inst_block_sigs = 6'h00;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_free();
    step(1);
    reset = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_block"}, 32'(block), 32'd0);
    check({tag, "_pulse"}, 32'(block_pulse), 32'd0);
    check({tag, "_mask"},  32'(blocked_mask), 32'd0);
    check({tag, "_idx"},   32'(first_blk_idx), 32'd0);
    check({tag, "_abort"}, 32'(abort_count), 32'd0);
    check({tag, "_state"}, 32'(state), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    axis_block_sigs = 2'b00;
    inst_idle_sigs  = 9'h1FF;
    inst_block_sigs = 6'h00;
    @(negedge clock);
    step(2);
    check_reset_vals("rst0");
    reset = 1'b1;

    // Basic detection: 8 consecutive stuck edges.
    drive_stuck();
    step(7);
    check("det_pre_block", 32'(block), 32'd0);
    check("det_pre_state", 32'(state), 32'd1);
    step(1);
    check("det_block", 32'(block), 32'd1);
    check("det_pulse", 32'(block_pulse), 32'd1);
    check("det_mask",  32'(blocked_mask), 32'h01);
    check("det_idx",   32'(first_blk_idx), 32'd0);
    check("det_state", 32'(state), 32'd2);
    step(1);
    check("det_pulse_off", 32'(block_pulse), 32'd0);
    check("det_block_sticky", 32'(block), 32'd1);

    // Reset while BLOCKED.
    do_reset();
    check_reset_vals("rst_blk");

    // AXIS port waiting prevents any suspicion.
    drive_stuck();
    axis_block_sigs = 2'b01;
    step(100);
    check("axis_block", 32'(block), 32'd0);
    check("axis_state", 32'(state), 32'd0);
    check("axis_abort", 32'(abort_count), 32'd0);

    // Aborted window, then a fresh full window.
    drive_stuck();
    step(7);
    check("abort_pre_state", 32'(state), 32'd1);
    drive_free();
    step(1);
    check("abort_state", 32'(state), 32'd0);
    check("abort_count1", 32'(abort_count), 32'd1);
    drive_stuck();
    step(7);
    check("abort_7_block", 32'(block), 32'd0);
    step(1);
    check("abort_8_block", 32'(block), 32'd1);
    check("abort_8_pulse", 32'(block_pulse), 32'd1);

    do_reset();
    check_reset_vals("rst_blk2");

    // Kernel fully idle: never suspect.
    inst_idle_sigs  = 9'h1FF;
    inst_block_sigs = 6'h00;
    step(50);
    check("idle_state", 32'(state), 32'd0);
    check("idle_block", 32'(block), 32'd0);

    // Blocked on instances 3 and 5; snapshot must freeze afterwards.
    inst_idle_sigs  = 9'h017;
    inst_block_sigs = 6'h28;
    step(8);
    check("multi_block", 32'(block), 32'd1);
    check("multi_mask",  32'(blocked_mask), 32'h28);
    check("multi_idx",   32'(first_blk_idx), 32'd3);
    inst_block_sigs = 6'h00;
    step(5);
    check("frz_mask",  32'(blocked_mask), 32'h28);
    check("frz_idx",   32'(first_blk_idx), 32'd3);
    check("frz_state", 32'(state), 32'd2);
    check("frz_block", 32'(block), 32'd1);
    check("frz_pulse", 32'(block_pulse), 32'd0);

    do_reset();

    // Reset on the very edge that would declare deadlock.
    drive_stuck();
    step(7);
    check("pre_state", 32'(state), 32'd1);
    reset = 1'b0;
    step(1);
    check_reset_vals("rst_decl");
    reset = 1'b1;
    drive_free();
    step(1);
    check("post_rst_pulse", 32'(block_pulse), 32'd0);
    check("post_rst_block", 32'(block), 32'd0);

    // Saturation of abort_count.
    for (int i = 0; i < 65534; i++) begin
      drive_stuck();
      step(1);
      drive_free();
      step(1);
    end
    check("sat_fffe", 32'(abort_count), 32'hFFFE);
    drive_stuck();
    step(1);
    drive_free();
    step(1);
    check("sat_ffff", 32'(abort_count), 32'hFFFF);
    for (int i = 0; i < 3; i++) begin
      drive_stuck();
      step(1);
      drive_free();
      step(1);
    end
    check("sat_hold", 32'(abort_count), 32'hFFFF);
    check("sat_block", 32'(block), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
